// File: rtl/mem_interface.sv
// Unified instruction/data memory port for the multi-cycle MIPS datapath.
// Optional feature: define MISALIGN_TRAP_EN to drop misaligned accesses and set a sticky misalign flag.
module mem_interface #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IorD,
  input  logic              MemWrite,
  input  logic              IRWrite,
  input  logic [31:0]       PC,
  input  logic [31:0]       ALUOut,
  input  logic [31:0]       WriteData,
  output logic [31:0]       Instr,
  output logic [31:0]       Data,
  output logic              Stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              misalign
);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {KIND_WRITE, KIND_FETCH, KIND_LOAD} kind_t;

  state_t      state;
  kind_t       kind;
  logic        is_write;
  logic        is_fetch;
  logic        is_load;
  logic        is_op;
  logic        start_c;
  logic        trap_c;
  logic [31:0] effaddr;
  kind_t       next_kind;
  logic        unused_addr_bits;

`ifdef MISALIGN_TRAP_EN
  logic trap_hold;
`endif

  // Op decode in priority order: store beats fetch beats load.
  always_comb begin
    is_write  = MemWrite;
    is_fetch  = IRWrite & ~MemWrite;
    is_load   = IorD & ~MemWrite & ~IRWrite;
    is_op     = is_write | is_fetch | is_load;
    effaddr   = IorD ? ALUOut : PC;
    next_kind = is_write ? KIND_WRITE : (is_fetch ? KIND_FETCH : KIND_LOAD);
`ifdef MISALIGN_TRAP_EN
    // The cycle after a trap ignores the (dropped) op so Stall releases the FSM.
    start_c   = (state == IDLE) & is_op & ~trap_hold;
    trap_c    = start_c & (effaddr[1:0] != 2'b00);
`else
    start_c   = (state == IDLE) & is_op;
    trap_c    = 1'b0;
`endif
  end

  assign unused_addr_bits = ^{effaddr[31:ADDR_W+2], effaddr[1:0]};

  always_comb begin
    Stall = 1'b0;
    if (!rst) begin
      Stall = start_c | ((state == BUSY) & ~mem_ack);
    end
  end

  // Transaction FSM; request fields stay frozen from issue through the ack cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      kind      <= KIND_FETCH;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      Instr     <= '0;
      Data      <= '0;
`ifdef MISALIGN_TRAP_EN
      trap_hold <= 1'b0;
      misalign  <= 1'b0;
`endif
    end else begin
`ifdef MISALIGN_TRAP_EN
      trap_hold <= trap_c;
      if (trap_c) begin
        misalign <= 1'b1;
      end
`endif
      case (state)
        IDLE: begin
          if (start_c && !trap_c) begin
            state     <= BUSY;
            kind      <= next_kind;
            mem_req   <= 1'b1;
            mem_we    <= is_write;
            mem_addr  <= effaddr[ADDR_W+1:2];
            mem_wdata <= WriteData;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (kind == KIND_FETCH) begin
              Instr <= mem_rdata;
            end
            if (kind == KIND_LOAD) begin
              Data <= mem_rdata;
            end
          end
        end
      endcase
    end
  end

`ifndef MISALIGN_TRAP_EN
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_interface.sv
// Scoreboard bench for mem_interface: randomized ops against a variable-latency memory model.
// Honors MISALIGN_TRAP_EN when the design is built with it.
module tb_mem_interface;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rst;
  logic              IorD;
  logic              MemWrite;
  logic              IRWrite;
  logic [31:0]       PC;
  logic [31:0]       ALUOut;
  logic [31:0]       WriteData;
  logic [31:0]       Instr;
  logic [31:0]       Data;
  logic              Stall;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;
  logic              misalign;

  mem_interface #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .PC(PC), .ALUOut(ALUOut), .WriteData(WriteData), .Instr(Instr), .Data(Data),
    .Stall(Stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 = write, 1 = fetch, 2 = load
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [1:0]        kind;
    logic [31:0]       rdata;
  } exp_t;

  exp_t        exp_q[$];
  int          tests;
  int          fails;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] mem_dev [DEPTH];
  int          dev_waits;
  logic        force_ack;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Backing memory: acks after dev_waits extra cycles of mem_req.
  initial begin
    int cnt;
    cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    for (int i = 0; i < DEPTH; i++) mem_dev[i] = init_word(i);
    forever begin
      @(negedge clk);
      #1;
      mem_ack = 1'b0;
      if (mem_req) begin
        if (cnt >= dev_waits) begin
          mem_ack = 1'b1;
          mem_rdata = mem_we ? 32'hFFFF_FFFF : mem_dev[mem_addr];
          if (mem_we) mem_dev[mem_addr] = mem_wdata;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
      if (force_ack) begin
        mem_ack = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
      end
    end
  end

  // Monitor: per-cycle check of request fields, captured registers and scoreboard pops.
  initial begin
    logic [31:0] exp_instr;
    logic [31:0] exp_data;
    exp_instr = 32'h0;
    exp_data  = 32'h0;
    forever begin
      @(negedge clk);
      #2;
      check("instr_reg", Instr, exp_instr);
      check("data_reg", Data, exp_data);
`ifndef MISALIGN_TRAP_EN
      check("misalign_tied", 32'(misalign), 32'h0);
`endif
      if (mem_req) begin
        if (exp_q.size() == 0) begin
          check("req_without_op", 32'(mem_req), 32'h0);
        end else begin
          check("mem_we", 32'(mem_we), 32'(exp_q[0].we));
          check("mem_addr", 32'(mem_addr), 32'(exp_q[0].addr));
          if (exp_q[0].we) check("mem_wdata", mem_wdata, exp_q[0].wdata);
          if (mem_ack) begin
            if (exp_q[0].kind == 2'd1) exp_instr = exp_q[0].rdata;
            if (exp_q[0].kind == 2'd2) exp_data = exp_q[0].rdata;
            void'(exp_q.pop_front());
          end
        end
      end
      if (rst) begin
        exp_q.delete();
        exp_instr = 32'h0;
        exp_data  = 32'h0;
      end
    end
  end

  task automatic do_op(input logic mw, input logic irw, input logic iord,
                       input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] wd,
                       input int waits, input bit perturb);
    logic              wr, fe, ld, op, trap;
    logic [31:0]       eff;
    logic [ADDR_W-1:0] wa;
    exp_t              e;
    int                exp_stall;
    int                stall_cnt;
    wr  = mw;
    fe  = irw & ~mw;
    ld  = iord & ~mw & ~irw;
    op  = wr | fe | ld;
    eff = iord ? alu : pc;
    wa  = eff[ADDR_W+1:2];
`ifdef MISALIGN_TRAP_EN
    trap = op && (eff[1:0] != 2'b00);
`else
    trap = 1'b0;
`endif
    @(negedge clk);
    MemWrite = mw; IRWrite = irw; IorD = iord;
    PC = pc; ALUOut = alu; WriteData = wd;
    dev_waits = waits;
    if (op && !trap) begin
      e.we    = wr;
      e.addr  = wa;
      e.wdata = wd;
      e.kind  = wr ? 2'd0 : (fe ? 2'd1 : 2'd2);
      e.rdata = wr ? 32'h0 : ref_mem[wa];
      if (wr) ref_mem[wa] = wd;
      exp_q.push_back(e);
    end
    exp_stall = !op ? 0 : (trap ? 1 : waits + 1);
    stall_cnt = 0;
    for (int c = 0; c < 64; c++) begin
      #3;
      if (c == 1 && op && !trap) check("req_after_issue", 32'(mem_req), 32'h1);
      if (c == 1 && trap) begin
        check("trap_no_req", 32'(mem_req), 32'h0);
        check("trap_misalign", 32'(misalign), 32'h1);
      end
      if (!Stall) break;
      stall_cnt++;
      if (perturb && c >= 1) begin
        WriteData = $urandom();
        PC        = $urandom();
        ALUOut    = $urandom();
      end
      @(negedge clk);
    end
    check("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      MemWrite = 1'b0; IRWrite = 1'b0; IorD = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    MemWrite = 1'b0; IRWrite = 1'b0; IorD = 1'b0;
    PC = 32'h0; ALUOut = 32'h0; WriteData = 32'h0;
    dev_waits = 0;
    force_ack = 1'b0;
    tests = 0;
    fails = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);

    repeat (2) @(negedge clk);
    #3;
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_stall", 32'(Stall), 32'h0);
    check("rst_misalign", 32'(misalign), 32'h0);
    rst = 1'b0;

    // Store with data perturbed while busy, then store with fetch also requested.
    do_op(1'b1, 1'b0, 1'b1, 32'h0, 32'h0000_0010, 32'h1234_5678, 2, 1'b1);
    do_op(1'b1, 1'b1, 1'b1, 32'h0000_0008, 32'h0000_0008, 32'h2002_0005, 0, 1'b0);
    check("priority_instr_kept", Instr, 32'h0);
    // Back-to-back zero-wait fetch.
    do_op(1'b0, 1'b1, 1'b0, 32'h0000_0008, 32'h0, 32'h0, 0, 1'b0);
    idle(1);
    #3;
    check("fetch_instr", Instr, 32'h2002_0005);
    do_op(1'b1, 1'b0, 1'b1, 32'h0, 32'h0000_0044, 32'hDEAD_BEEF, 1, 1'b0);
    idle(1);
    do_op(1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_0044, 32'h0, 3, 1'b1);
    idle(1);
    #3;
    check("load_data", Data, 32'hDEAD_BEEF);
    check("load_instr_kept", Instr, 32'h2002_0005);

    // Misaligned load: trapped or executed at the truncated address depending on build.
    do_op(1'b1, 1'b0, 1'b1, 32'h0, 32'h0000_0044, 32'h0BAD_F00D, 0, 1'b0);
    do_op(1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_0046, 32'h0, 1, 1'b0);
    idle(2);
    #3;
`ifdef MISALIGN_TRAP_EN
    check("misalign_data_kept", Data, 32'hDEAD_BEEF);
    check("misalign_sticky", 32'(misalign), 32'h1);
`else
    check("misalign_trunc_data", Data, 32'h0BAD_F00D);
`endif

    // Stray ack while idle.
    @(negedge clk);
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    #3;
    check("idle_ack_req", 32'(mem_req), 32'h0);
    check("idle_ack_stall", 32'(Stall), 32'h0);

    // Reset in the second busy cycle, with a late ack afterwards.
    @(negedge clk);
    MemWrite = 1'b0; IRWrite = 1'b0; IorD = 1'b1; ALUOut = 32'h0000_0044;
    dev_waits = 3;
    exp_q.push_back('{we: 1'b0, addr: ADDR_W'(32'h11), wdata: 32'h0, kind: 2'd2, rdata: ref_mem[17]});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    IorD = 1'b0;
    #3;
    check("rst_forces_stall_low", 32'(Stall), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    force_ack = 1'b1;
    #3;
    check("abort_req_low", 32'(mem_req), 32'h0);
    @(negedge clk);
    force_ack = 1'b0;
    #3;
    check("abort_instr", Instr, 32'h0);
    check("abort_data", Data, 32'h0);
    check("abort_misalign", 32'(misalign), 32'h0);
    do_op(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h0, 1, 1'b0);

    // Random traffic, mixing idle gaps and back-to-back ops.
    for (int n = 0; n < 300; n++) begin
      int          r;
      logic        mw, irw, iord;
      logic [31:0] pc, alu;
      r    = int'($urandom_range(0, 9));
      pc   = $urandom();
      alu  = $urandom();
`ifdef MISALIGN_TRAP_EN
      pc[1:0]  = 2'b00;
      alu[1:0] = 2'b00;
`endif
      if (r <= 2) begin
        mw = 1'b1; irw = 1'($urandom_range(0, 1)); iord = 1'($urandom_range(0, 1));
      end else if (r <= 5) begin
        mw = 1'b0; irw = 1'b1; iord = 1'($urandom_range(0, 1));
      end else if (r <= 8) begin
        mw = 1'b0; irw = 1'b0; iord = 1'b1;
      end else begin
        mw = 1'b0; irw = 1'b0; iord = 1'b0;
      end
      if ($urandom_range(0, 1) == 0) idle(1);
      do_op(mw, irw, iord, pc, alu, $urandom(), int'($urandom_range(0, 4)),
            1'($urandom_range(0, 1)));
    end

    idle(3);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
